// File: rtl/ts_client_arbiter.sv
`default_nettype none
//============================================================================
// Module   : ts_client_arbiter
// Brief    : Shares one event timestamper among NUM_CLIENTS requesters; owns
//            the event-ID pool and routes completed records to their owner.
// Revision : 1.0 - initial release
//============================================================================
module ts_client_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ID_W        = 4,
    localparam int CLI_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CLIENTS-1:0]      cli_start_valid,
    output logic [NUM_CLIENTS-1:0]      cli_start_ready,
    output logic [NUM_CLIENTS*ID_W-1:0] cli_start_id,
    input  logic [NUM_CLIENTS-1:0]      cli_end_valid,
    output logic [NUM_CLIENTS-1:0]      cli_end_ready,
    input  logic [NUM_CLIENTS*ID_W-1:0] cli_end_id,
    output logic                        ts_start_valid,
    input  logic                        ts_start_ready,
    output logic [ID_W-1:0]             ts_start_id,
    output logic                        ts_end_valid,
    input  logic                        ts_end_ready,
    output logic [ID_W-1:0]             ts_end_id,
    input  logic                        rec_valid,
    input  logic                        rec_ready,
    input  logic [ID_W-1:0]             rec_id,
    output logic [CLI_W-1:0]            rec_owner,
    output logic [ID_W:0]               inflight,
    output logic                        end_err,
    output logic [15:0]                 err_cnt
);

    localparam int DEPTH = 2 ** ID_W;

    localparam logic [1:0] c_FREE   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_ENDING = 2'd2;

    logic [1:0]       r_state [DEPTH];
    logic [CLI_W-1:0] r_owner [DEPTH];
    logic [CLI_W-1:0] r_start_ptr;
    logic [CLI_W-1:0] r_end_ptr;
    logic [ID_W:0]    r_inflight;
    logic             r_end_err;
    logic [15:0]      r_err_cnt;

    logic [ID_W-1:0]  w_alloc_id;
    logic             w_free_any;
    logic [CLI_W-1:0] w_start_win;
    logic             w_start_fire;
    logic [CLI_W-1:0] w_end_win;
    logic             w_end_any;
    logic [ID_W-1:0]  w_end_id;
    logic             w_end_legal;
    logic             w_end_fire;
    logic             w_end_drop;
    logic             w_rec_free;

    // First requester at or after ptr, wrapping round.
    function automatic logic [CLI_W-1:0] f_rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                   input logic [CLI_W-1:0]       ptr);
        logic [CLI_W-1:0] pick;
        int               idx;
        pick = ptr;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CLIENTS;
            if (req[CLI_W'(idx)]) pick = CLI_W'(idx);
        end
        return pick;
    endfunction

    function automatic logic [CLI_W-1:0] f_next(input logic [CLI_W-1:0] c);
        return (c == CLI_W'(NUM_CLIENTS - 1)) ? '0 : c + CLI_W'(1);
    endfunction

    always_comb begin
        w_alloc_id = '0;
        w_free_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == c_FREE) begin
                w_alloc_id = ID_W'(i);
                w_free_any = 1'b1;
            end
        end
    end

    assign w_start_win    = f_rr_pick(cli_start_valid, r_start_ptr);
    assign ts_start_valid = (|cli_start_valid) & w_free_any;
    assign ts_start_id    = w_alloc_id;
    assign w_start_fire   = ts_start_valid & ts_start_ready;

    always_comb begin
        cli_start_ready = '0;
        cli_start_id    = '0;
        if (ts_start_valid) begin
            cli_start_ready[w_start_win]               = ts_start_ready;
            cli_start_id[w_start_win*ID_W +: ID_W]     = w_alloc_id;
        end
    end

    // Illegal ends are acknowledged to the client but never reach the timestamper.
    assign w_end_any    = |cli_end_valid;
    assign w_end_win    = f_rr_pick(cli_end_valid, r_end_ptr);
    assign w_end_id     = cli_end_id[w_end_win*ID_W +: ID_W];
    assign w_end_legal  = (r_state[w_end_id] == c_ACTIVE) && (r_owner[w_end_id] == w_end_win);
    assign ts_end_valid = w_end_any & w_end_legal;
    assign ts_end_id    = w_end_id;
    assign w_end_fire   = ts_end_valid & ts_end_ready;
    assign w_end_drop   = w_end_any & ~w_end_legal;

    always_comb begin
        cli_end_ready = '0;
        if (w_end_any) begin
            cli_end_ready[w_end_win] = w_end_legal ? ts_end_ready : 1'b1;
        end
    end

    assign rec_owner  = r_owner[rec_id];
    assign w_rec_free = rec_valid & rec_ready & (r_state[rec_id] == c_ENDING);

    // Start, end and record always touch distinct IDs, so all three may land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_FREE;
                r_owner[i] <= '0;
            end
            r_start_ptr <= '0;
            r_end_ptr   <= '0;
            r_inflight  <= '0;
            r_end_err   <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_rec_free) begin
                r_state[rec_id] <= c_FREE;
            end
            if (w_start_fire) begin
                r_state[w_alloc_id] <= c_ACTIVE;
                r_owner[w_alloc_id] <= w_start_win;
                r_start_ptr         <= f_next(w_start_win);
            end
            if (w_end_fire) begin
                r_state[w_end_id] <= c_ENDING;
                r_end_ptr         <= f_next(w_end_win);
            end
            if (w_end_drop) begin
                r_end_ptr <= f_next(w_end_win);
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
            r_end_err <= w_end_drop;
            case ({w_start_fire, w_rec_free})
                2'b10:   r_inflight <= r_inflight + (ID_W+1)'(1);
                2'b01:   r_inflight <= r_inflight - (ID_W+1)'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight = r_inflight;
    assign end_err  = r_end_err;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ts_client_arbiter.sv
`default_nettype none
//============================================================================
// Module   : tb_ts_client_arbiter
// Brief    : Directed scenarios plus randomized traffic against a pool model.
// Revision : 1.0 - initial release
//============================================================================
module tb_ts_client_arbiter;

    localparam int NC     = 4;
    localparam int IW     = 4;
    localparam int DEPTH  = 16;
    localparam int FREE   = 0;
    localparam int ACTIVE = 1;
    localparam int ENDING = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   cli_start_valid, cli_start_ready, cli_end_valid, cli_end_ready;
    logic [NC*IW-1:0] cli_start_id, cli_end_id;
    logic            ts_start_valid, ts_start_ready, ts_end_valid, ts_end_ready;
    logic [IW-1:0]   ts_start_id, ts_end_id, rec_id;
    logic            rec_valid, rec_ready, end_err;
    logic [1:0]      rec_owner;
    logic [IW:0]     inflight;
    logic [15:0]     err_cnt;

    always #5 clk = ~clk;

    ts_client_arbiter #(.NUM_CLIENTS(NC), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cli_start_valid(cli_start_valid), .cli_start_ready(cli_start_ready),
        .cli_start_id(cli_start_id),
        .cli_end_valid(cli_end_valid), .cli_end_ready(cli_end_ready),
        .cli_end_id(cli_end_id),
        .ts_start_valid(ts_start_valid), .ts_start_ready(ts_start_ready),
        .ts_start_id(ts_start_id),
        .ts_end_valid(ts_end_valid), .ts_end_ready(ts_end_ready), .ts_end_id(ts_end_id),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
        .rec_owner(rec_owner), .inflight(inflight), .end_err(end_err), .err_cnt(err_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pool model: per-ID lifecycle, owner and the two round-robin positions.
    int   m_state [DEPTH];
    int   m_owner [DEPTH];
    int   m_sptr, m_eptr, m_errcnt;
    logic m_end_err;

    int          e_alloc, e_swin, e_ewin, e_teid, e_inflight;
    logic        e_tsv, e_tev, e_legal;
    logic [3:0]  e_sready, e_eready;

    task automatic predict();
        e_alloc = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (m_state[i] == FREE) e_alloc = i;
        e_swin = -1;
        e_ewin = -1;
        for (int k = 0; k < NC; k++) begin
            if (e_swin < 0 && cli_start_valid[(m_sptr + k) % NC]) e_swin = (m_sptr + k) % NC;
            if (e_ewin < 0 && cli_end_valid[(m_eptr + k) % NC])   e_ewin = (m_eptr + k) % NC;
        end
        e_tsv    = (e_swin >= 0) && (e_alloc >= 0);
        e_sready = (e_tsv && ts_start_ready) ? 4'(1 << e_swin) : 4'b0;
        e_legal  = 1'b0;
        e_teid   = 0;
        e_eready = 4'b0;
        if (e_ewin >= 0) begin
            e_teid   = int'(cli_end_id[e_ewin*IW +: IW]);
            e_legal  = (m_state[e_teid] == ACTIVE) && (m_owner[e_teid] == e_ewin);
            e_eready = (!e_legal || ts_end_ready) ? 4'(1 << e_ewin) : 4'b0;
        end
        e_tev      = e_legal;
        e_inflight = 0;
        for (int i = 0; i < DEPTH; i++) if (m_state[i] != FREE) e_inflight++;
    endtask

    // Advance one clock, applying the current inputs to the model as well.
    task automatic commit();
        logic sfire, efire, rfree;
        int   rid;
        predict();
        sfire = e_tsv && ts_start_ready;
        efire = e_legal && ts_end_ready;
        rid   = int'(rec_id);
        rfree = rec_valid && rec_ready && (m_state[rid] == ENDING);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_state[i] = FREE;
                m_owner[i] = 0;
            end
            m_sptr = 0; m_eptr = 0; m_errcnt = 0; m_end_err = 1'b0;
        end else begin
            if (rfree) m_state[rid] = FREE;
            if (sfire) begin
                m_state[e_alloc] = ACTIVE;
                m_owner[e_alloc] = e_swin;
                m_sptr = (e_swin + 1) % NC;
            end
            m_end_err = 1'b0;
            if (e_ewin >= 0) begin
                if (!e_legal) begin
                    m_eptr    = (e_ewin + 1) % NC;
                    m_end_err = 1'b1;
                    if (m_errcnt < 65535) m_errcnt++;
                end else if (efire) begin
                    m_state[e_teid] = ENDING;
                    m_eptr = (e_ewin + 1) % NC;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        cli_start_valid = '0; cli_end_valid = '0; cli_end_id = '0;
        rec_valid = 1'b0; rec_id = '0;
        ts_start_ready = 1'b1; ts_end_ready = 1'b1; rec_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        commit();
        commit();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({cli_start_ready, cli_end_ready, ts_start_valid, ts_end_valid, end_err, inflight, err_cnt} !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: sready=%b eready=%b tsv=%b tev=%b err=%b infl=%0d cnt=%0d, required all 0",
                         i, cli_start_ready, cli_end_ready, ts_start_valid, ts_end_valid, end_err, inflight, err_cnt);
            end
            commit();
        end
    endtask

    task automatic test_basic();
        do_reset();
        cli_start_valid = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({cli_start_ready, cli_start_id[11:8]} !== {4'b0100, 4'(i)}) begin
                n_fail++;
                $display("FAIL basic_start%0d: ready=%b id=%0d, required ready=0100 id=%0d", i, cli_start_ready, cli_start_id[11:8], i);
            end
            commit();
        end
        cli_start_valid = '0;
        cli_end_valid = 4'b0100;
        cli_end_id[11:8] = 4'd0;
        #1;
        n_checks++;
        if (inflight !== 5'd2) begin
            n_fail++; $display("FAIL basic_inflight2: got %0d required 2", inflight);
        end
        n_checks++;
        if ({ts_end_valid, ts_end_id, cli_end_ready} !== {1'b1, 4'd0, 4'b0100}) begin
            n_fail++;
            $display("FAIL basic_end: tev=%b id=%0d eready=%b, required 1/0/0100", ts_end_valid, ts_end_id, cli_end_ready);
        end
        commit();
        cli_end_valid = '0;
        rec_valid = 1'b1;
        rec_id = 4'd0;
        #1;
        n_checks++;
        if (rec_owner !== 2'd2) begin
            n_fail++; $display("FAIL basic_rec_owner: got %0d required 2", rec_owner);
        end
        commit();
        rec_valid = 1'b0;
        #1;
        n_checks++;
        if (inflight !== 5'd1) begin
            n_fail++; $display("FAIL basic_inflight1: got %0d required 1", inflight);
        end
        commit();
    endtask

    task automatic test_round_robin();
        int g [8] = '{0, 1, 2, 3, 0, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cli_start_valid = (i < 4) ? 4'b1111 : 4'b1101;
            #1;
            n_checks++;
            if ({cli_start_ready, ts_start_id} !== {4'(1 << g[i]), 4'(i)}) begin
                n_fail++;
                $display("FAIL rr_grant%0d: ready=%b id=%0d, required ready=%b id=%0d", i, cli_start_ready, ts_start_id, 4'(1 << g[i]), i);
            end
            commit();
        end
        idle();
    endtask

    task automatic test_pool_full();
        do_reset();
        cli_start_valid = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_checks++;
            if ({cli_start_ready, ts_start_id} !== {4'b0001, 4'(i)}) begin
                n_fail++; $display("FAIL fill%0d: ready=%b id=%0d, required 0001/%0d", i, cli_start_ready, ts_start_id, i);
            end
            commit();
        end
        cli_end_valid = 4'b0001;
        cli_end_id[3:0] = 4'd5;
        #1;
        n_checks++;
        if ({cli_start_ready, ts_start_valid, inflight, ts_end_valid} !== {4'b0000, 1'b0, 5'd16, 1'b1}) begin
            n_fail++;
            $display("FAIL full_stall: ready=%b tsv=%b infl=%0d tev=%b, required 0000/0/16/1", cli_start_ready, ts_start_valid, inflight, ts_end_valid);
        end
        commit();
        cli_end_valid = '0;
        rec_valid = 1'b1;
        rec_id = 4'd5;
        #1;
        n_checks++;
        if (cli_start_ready !== 4'b0000) begin
            n_fail++; $display("FAIL full_same_cycle_free: ready=%b required 0000", cli_start_ready);
        end
        commit();
        rec_valid = 1'b0;
        #1;
        n_checks++;
        if ({cli_start_ready, cli_start_id[3:0]} !== {4'b0001, 4'd5}) begin
            n_fail++; $display("FAIL full_realloc: ready=%b id=%0d, required 0001/5", cli_start_ready, cli_start_id[3:0]);
        end
        commit();
        idle();
    endtask

    task automatic test_illegal_end();
        do_reset();
        cli_start_valid = 4'b0001;
        for (int i = 0; i < 5; i++) commit();
        cli_start_valid = '0;
        cli_end_valid = 4'b0001;
        cli_end_id[3:0] = 4'd4;
        commit();
        cli_end_valid = 4'b0010;
        cli_end_id[7:4] = 4'd3;
        #1;
        n_checks++;
        if ({cli_end_ready, ts_end_valid} !== {4'b0010, 1'b0}) begin
            n_fail++; $display("FAIL wrong_owner_drop: eready=%b tev=%b, required 0010/0", cli_end_ready, ts_end_valid);
        end
        commit();
        cli_end_valid = '0;
        #1;
        n_checks++;
        if ({end_err, err_cnt} !== {1'b1, 16'd1}) begin
            n_fail++; $display("FAIL wrong_owner_err: end_err=%b err_cnt=%0d, required 1/1", end_err, err_cnt);
        end
        commit();
        #1;
        n_checks++;
        if (end_err !== 1'b0) begin
            n_fail++; $display("FAIL end_err_pulse: end_err=%b required 0", end_err);
        end
        cli_end_valid = 4'b0001;
        cli_end_id[3:0] = 4'd4;
        #1;
        n_checks++;
        if ({cli_end_ready, ts_end_valid} !== {4'b0001, 1'b0}) begin
            n_fail++; $display("FAIL ending_drop: eready=%b tev=%b, required 0001/0", cli_end_ready, ts_end_valid);
        end
        commit();
        cli_end_valid = '0;
        #1;
        n_checks++;
        if ({end_err, err_cnt} !== {1'b1, 16'd2}) begin
            n_fail++; $display("FAIL ending_err: end_err=%b err_cnt=%0d, required 1/2", end_err, err_cnt);
        end
        commit();
    endtask

    // Runs after test_illegal_end: IDs 0..3 active, owner 0.
    task automatic test_backpressure_and_reset();
        ts_end_ready = 1'b0;
        cli_end_valid = 4'b0001;
        cli_end_id[3:0] = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({ts_end_valid, cli_end_ready, ts_end_id} !== {1'b1, 4'b0000, 4'd2}) begin
                n_fail++;
                $display("FAIL end_stall%0d: tev=%b eready=%b id=%0d, required 1/0000/2", i, ts_end_valid, cli_end_ready, ts_end_id);
            end
            commit();
        end
        cli_start_valid = 4'b1111;
        rst = 1'b1;
        commit();
        rst = 1'b0;
        cli_start_valid = 4'b0001;
        ts_end_ready = 1'b1;
        #1;
        n_checks++;
        if ({inflight, err_cnt, cli_start_ready, ts_start_id} !== {5'd0, 16'd0, 4'b0001, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: infl=%0d cnt=%0d sready=%b sid=%0d, required 0/0/0001/0", inflight, err_cnt, cli_start_ready, ts_start_id);
        end
        n_checks++;
        if ({ts_end_valid, cli_end_ready} !== {1'b0, 4'b0001}) begin
            n_fail++; $display("FAIL mid_reset_freed: tev=%b eready=%b, required 0/0001", ts_end_valid, cli_end_ready);
        end
        commit();
        idle();
    endtask

    task automatic test_random();
        logic [45:0] act, exp;
        logic [3:0]  gid;
        int          ends [$];
        int          pick, off, x;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst            = ($urandom_range(199) == 0);
            cli_start_valid = 4'($urandom);
            ts_start_ready = ($urandom_range(3) != 0);
            ts_end_ready   = ($urandom_range(3) != 0);
            cli_end_valid  = '0;
            for (int c = 0; c < NC; c++) begin
                cli_end_valid[c] = ($urandom_range(2) == 0);
                pick = -1;
                off  = $urandom_range(DEPTH - 1);
                for (int j = 0; j < DEPTH; j++) begin
                    x = (off + j) % DEPTH;
                    if (pick < 0 && m_state[x] == ACTIVE && m_owner[x] == c) pick = x;
                end
                if (pick < 0 || $urandom_range(3) == 0) pick = $urandom_range(DEPTH - 1);
                cli_end_id[c*IW +: IW] = 4'(pick);
            end
            ends.delete();
            for (int i = 0; i < DEPTH; i++) if (m_state[i] == ENDING) ends.push_back(i);
            rec_ready = ($urandom_range(3) != 0);
            if (ends.size() > 0 && $urandom_range(1) == 0) begin
                rec_valid = 1'b1;
                rec_id    = 4'(ends[$urandom_range(ends.size() - 1)]);
            end else begin
                rec_valid = 1'b0;
                rec_id    = 4'($urandom);
            end
            #1;
            predict();
            gid = '0;
            for (int c = NC - 1; c >= 0; c--) if (cli_start_ready[c]) gid = cli_start_id[c*IW +: IW];
            act = {ts_start_valid, cli_start_ready, (ts_start_valid ? ts_start_id : 4'd0), gid,
                   ts_end_valid, (ts_end_valid ? ts_end_id : 4'd0), cli_end_ready,
                   (rec_valid ? rec_owner : 2'd0), inflight, end_err, err_cnt};
            exp = {e_tsv, e_sready, (e_tsv ? 4'(e_alloc) : 4'd0), ((e_sready != 0) ? 4'(e_alloc) : 4'd0),
                   e_tev, (e_tev ? 4'(e_teid) : 4'd0), e_eready,
                   (rec_valid ? 2'(m_owner[int'(rec_id)]) : 2'd0), 5'(e_inflight), m_end_err, 16'(m_errcnt)};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h required %h", cyc, act, exp);
            end
            commit();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            m_state[i] = FREE;
            m_owner[i] = 0;
        end
        m_sptr = 0; m_eptr = 0; m_errcnt = 0; m_end_err = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_pool_full();
        test_illegal_end();
        test_backpressure_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ts_client_arbiter.md
Name: ts_client_arbiter

Overview:
Front-end controller that shares one event_timestamper instance among NUM_CLIENTS requesters. It owns the event-ID pool: it allocates a free ID on each client start and round-robin arbitrates start and end requests onto the timestamper's single start/end ports. It records which client owns each ID so that completed timestamp records can be routed back to their owner. It sits between the client logic (e.g. UDP TX/RX taps) and the timestamper, and it also observes the timestamper's output handshake.

Parameters:
NUM_CLIENTS, 4, number of requesters (≥2)
ID_W, 4, event-ID width; must match the timestamper; pool size DEPTH = 2**ID_W
CLI_W, max(1,$clog2(NUM_CLIENTS)), client index width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high, clock clk
cli_start_valid  in  NUM_CLIENTS  per-client start request
cli_start_ready  out  NUM_CLIENTS  one-hot grant; the handshake completes in the same cycle
cli_start_id  out  NUM_CLIENTS*ID_W  allocated ID; client c uses slice [c*ID_W +: ID_W]; valid only with its grant
cli_end_valid  in  NUM_CLIENTS  per-client end request
cli_end_ready  out  NUM_CLIENTS  one-hot end grant
cli_end_id  in  NUM_CLIENTS*ID_W  ID being ended, same slicing as cli_start_id
ts_start_valid / ts_start_ready / ts_start_id  out/in/out  1/1/ID_W  to timestamper start port
ts_end_valid / ts_end_ready / ts_end_id  out/in/out  1/1/ID_W  to timestamper end port
rec_valid, rec_ready  in  1 each  tap of timestamper out_valid and downstream out_ready
rec_id  in  ID_W  tap of timestamper out_id
rec_owner  out  CLI_W  owner of rec_id (combinational lookup)
inflight  out  ID_W+1  count of IDs not FREE
end_err  out  1  one-cycle pulse when an illegal end is dropped
err_cnt  out  16  saturating count of dropped ends

Behaviour:
- Each ID has a registered 2-bit state with three values: FREE, ACTIVE and ENDING. Each ID also has a registered owner[CLI_W].
- Reset: all IDs FREE, owners 0, both round-robin pointers 0, inflight 0, err_cnt 0, end_err 0. All grants and ts_*_valid are 0 on the first cycle after reset.
- A reset during operation abandons all IDs with no records emitted. The timestamper shares rst, so both blocks clear together.
- Start path (combinational):
  - alloc_id = lowest-numbered FREE ID.
  - ts_start_valid = (any cli_start_valid) AND (a FREE ID exists).
  - Winner = first requesting client at or after start_ptr, round-robin.
  - ts_start_id = alloc_id.
  - cli_start_ready[winner] = ts_start_ready; cli_start_id[winner] = alloc_id.
- Start fire (ts_start_valid & ts_start_ready), at the clock edge:
  - state[alloc_id] becomes ACTIVE and owner[alloc_id] becomes winner.
  - start_ptr becomes winner+1 mod NUM_CLIENTS.
  - Without a fire, the pointer holds.
- ts_start_valid and ts_start_id may change or drop without a handshake; the timestamper tolerates this.
- End path: the winner is the first requesting client at or after end_ptr. Its request is legal only if state[cli_end_id]==ACTIVE and owner==winner.
  - Legal request: ts_end_valid=1, ts_end_id=cli_end_id, and cli_end_ready[winner]=ts_end_ready.
    - On fire, state becomes ENDING and end_ptr advances past the winner.
  - Illegal request: ts_end_valid=0 and cli_end_ready[winner]=1, so the request is consumed and dropped.
    - end_err pulses in the next cycle (registered); err_cnt increments, saturating at 16'hFFFF.
    - end_ptr advances.
- Record path:
  - rec_owner = owner[rec_id], combinational.
  - When rec_valid & rec_ready, state[rec_id] returns to FREE at the edge.
  - An ID is therefore never reallocated before its record is consumed, so rec_owner is always correct.
- Pool full (no FREE ID): ts_start_valid=0 and all cli_start_ready=0. Start pointers hold.
- A record that frees ID X in cycle t makes X allocatable from cycle t+1, not in t.
- Same cycle, same ID, start and end: impossible, because alloc_id is always FREE and a legal end ID is always ACTIVE.
- Start fire, end fire and record free on distinct IDs in one cycle: all three take effect at the edge. inflight changes by +1 for a start fire and −1 for a record free.
- Record on an ID that is not ENDING: ignored. The bench asserts this never occurs.
- No other latency is added: client handshakes coincide with the timestamper handshakes.

Test Plan:
- Reset, then idle 5 cycles -> all ready/valid 0, inflight=0, err_cnt=0.
- Client 2 starts twice -> gets IDs 0 then 1, owner=2, inflight=2. Client 2 ends ID 0 -> ts_end_id=0. Record rec_id=0 fires -> rec_owner=2, ID 0 FREE next cycle, inflight=1.
- Clients 0–3 hold start_valid together -> grants in order 0,1,2,3 on consecutive cycles with IDs 0,1,2,3. Dropping client 1 mid-sequence skips it.
- 16 starts fill the pool; a 17th request stalls with cli_start_ready=0. After the ID 5 record fires, the stalled client gets ID 5 on the next cycle.
- Client 1 ends ID 3, which is owned by client 0 -> cli_end_ready[1]=1, ts_end_valid=0, end_err one pulse, err_cnt=1. A repeated end on ENDING ID 4 -> err_cnt=2.
- ts_end_ready held 0 for 4 cycles -> cli_end_ready=0 and the ID stays ACTIVE. Asserting rst mid-stream -> every ID FREE, inflight=0 on the next cycle.
